lpif_txfifo_x16_q2: RTL and testbench

Synchronous transmit buffer that takes the packed 1166-bit LPIF downstream word from the x16 quarter-rate txrx packer. It holds up to DEPTH words and presents them first-word-fall-through to the logic-link transmit side with a valid/ready handshake. It absorbs short back-pressure from the link and flags any word lost to overflow.

---
 rtl/lpif_txfifo_x16_q2.sv | 57 +++++
 tb/tb_lpif_txfifo_x16_q2.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lpif_txfifo_x16_q2.sv
// lpif_txfifo_x16_q2: first-word-fall-through transmit FIFO for packed LPIF downstream words.
module lpif_txfifo_x16_q2 #(
  parameter int WIDTH    = 1166,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input  logic                     clk_wr,
  input  logic                     rst_wr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_TH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty       = wr_ptr_q == rd_ptr_q;
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = count >= AF_TH;
  assign rd_valid    = !empty;
  assign rd_data     = mem[rd_ptr_q[AW-1:0]];
  assign overflow    = overflow_q;
  assign push        = wr_en && !full;
  assign pop         = rd_valid && rd_ready;
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = (wr_en && full) || (overflow_q && !clr_overflow);
  end
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk_wr) begin
    if (push && !rst_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: tb/tb_lpif_txfifo_x16_q2.sv
// tb_lpif_txfifo_x16_q2: directed self-checking bench for the LPIF transmit FIFO.
module tb_lpif_txfifo_x16_q2;
  localparam int W = 1166;
  logic         clk_wr = 0;
  logic         rst_wr, wr_en, rd_ready, clr_overflow;
  logic [W-1:0] wr_data, rd_data;
  logic         rd_valid, full, empty, almost_full, overflow;
  logic [3:0]   count;
  int checks = 0;
  int errors = 0;
  always #5 clk_wr = ~clk_wr;
  lpif_txfifo_x16_q2 dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .full(full),
    .empty(empty), .almost_full(almost_full), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );
  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask
  task automatic idle();
    wr_en = 0; rd_ready = 0; clr_overflow = 0; rst_wr = 0;
  endtask
  task automatic test_reset();
    idle();
    wr_data = '0;
    rst_wr = 1;
    step(); step();
    rst_wr = 0;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b rd_valid=%b full=%b overflow=%b afull=%b required 0 1 0 0 0 0", count, empty, rd_valid, full, overflow, almost_full);
    end
    rd_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (count !== 4'd0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL underflow: count=%0d empty=%b required 0 1", count, empty);
      end
    end
    idle();
  endtask
  task automatic test_fill_drain();
    idle();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = W'(i);
      step();
      checks++;
      if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6)) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d afull=%b required %0d %b", i, count, almost_full, i + 1, (i + 1 >= 6));
      end
    end
    wr_en = 0;
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL full: full=%b count=%0d required 1 8", full, count);
    end
    rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data !== W'(i) || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d]: rd_data=%0h rd_valid=%b required %0h 1", i, rd_data, rd_valid, i);
      end
      step();
    end
    idle();
    checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL drained: empty=%b count=%0d required 1 0", empty, count);
    end
  endtask
  task automatic test_overflow();
    idle();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = W'(100 + i);
      step();
    end
    wr_data = W'(12'hAAA); rd_ready = 1;
    step();
    idle();
    checks++;
    if (count !== 4'd7 || overflow !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drop: count=%0d overflow=%b full=%b required 7 1 0", count, overflow, full);
    end
    wr_en = 1; wr_data = W'(200);
    step();
    wr_data = W'(300); clr_overflow = 1;
    step();
    idle();
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL set_wins: overflow=%b count=%0d required 1 8", overflow, count);
    end
    clr_overflow = 1;
    step();
    idle();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_overflow: overflow=%b required 0", overflow);
    end
    rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data !== W'(i < 7 ? 101 + i : 200)) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: rd_data=%0h required %0h", i, rd_data, (i < 7 ? 101 + i : 200));
      end
      step();
    end
    idle();
  endtask
  task automatic test_stream();
    idle();
    wr_en = 1; wr_data = W'(1000);
    step();
    rd_ready = 1;
    for (int i = 1; i <= 40; i++) begin
      wr_data = W'(1000 + i);
      checks++;
      if (rd_data !== W'(1000 + i - 1)) begin
        errors++;
        $display("FAIL stream_data[%0d]: rd_data=%0h required %0h", i, rd_data, 1000 + i - 1);
      end
      step();
      checks++;
      if (count !== 4'd1 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL stream_count[%0d]: count=%0d overflow=%b required 1 0", i, count, overflow);
      end
    end
    wr_en = 0;
    checks++;
    if (rd_data !== W'(1040)) begin
      errors++;
      $display("FAIL stream_last: rd_data=%0h required %0h", rd_data, 1040);
    end
    step();
    idle();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_empty: empty=%b required 1", empty);
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] rdy;
    idle();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = W'(50 + i);
      step();
    end
    wr_en = 0;
    rdy = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      rd_ready = rdy[3 - i];
      checks++;
      if (rd_data !== W'(i == 0 ? 50 : 51)) begin
        errors++;
        $display("FAIL hold[%0d]: rd_data=%0h required %0h", i, rd_data, (i == 0 ? 50 : 51));
      end
      step();
    end
    rd_ready = 0;
    checks++;
    if (count !== 4'd1 || rd_data !== W'(52)) begin
      errors++;
      $display("FAIL hold_consumed: count=%0d rd_data=%0h required 1 34", count, rd_data);
    end
    rd_ready = 1;
    step();
    idle();
  endtask
  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = W'(60 + i);
      step();
    end
    rst_wr = 1; wr_data = W'(99);
    step();
    idle();
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: empty=%b count=%0d rd_valid=%b required 1 0 0", empty, count, rd_valid);
    end
    wr_en = 1; wr_data = W'(77);
    step();
    idle();
    checks++;
    if (rd_data !== W'(77) || count !== 4'd1 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first: rd_data=%0h count=%0d rd_valid=%b required 4d 1 1", rd_data, count, rd_valid);
    end
  endtask
  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
